// File: rtl/montred_final_sub.sv
// montred_final_sub
//
// Final correction stage of the word-level Montgomery reduction chain for
// special primes q = 2^(current_k+K-8) - q_m*2^W + 1. Takes the signed result
// T of the last reduction stage (nominally in [-q, 2q)) and maps it into the
// canonical range [0, q). Three-stage, fully pipelined, one sample per cycle,
// no back-pressure. Each sample carries its own q_m/current_k, so consecutive
// samples may use different moduli.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (clears all valid bits and outputs)
//   in_valid   T, q_m and current_k are valid this cycle
//   in         signed T, two's complement, IN_BITS wide
//   q_m        modulus parameter (M bits), sampled with in_valid
//   current_k  modulus size select, 0 -> K-8 bits ... 8 -> K bits
//   out_valid  result valid, exactly 3 cycles after in_valid
//   out        reduced value in [0, q), low K bits of the selected candidate
//   range_err  input was outside [-q, 2q); qualified by out_valid

module montred_final_sub #(
    parameter int K       = 54,
    parameter int M       = 17,
    parameter int W       = 24,
    parameter int IN_BITS = K + 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [IN_BITS-1:0] in,
    input  logic [M-1:0]       q_m,
    input  logic [3:0]         current_k,
    output logic               out_valid,
    output logic [K-1:0]       out,
    output logic               range_err
);

    // q needs one bit more than K: the corner current_k=8, q_m=0 gives 2^K+1.
    localparam int QW = K + 1;
    // Differences are formed one bit wider than T so T - 2q cannot overflow.
    localparam int DW = IN_BITS + 1;
    // Exponent of the leading power of two when current_k = 0.
    localparam int K_BASE = K - 8;

    // ------------------------------------------------------------------
    // Stage 1: build q from (q_m, current_k) and register it with T.
    // ------------------------------------------------------------------
    logic [5:0]    shift_amt;
    logic [QW-1:0] q_calc;

    always_comb begin
        // Illegal current_k (>8) shifts the leading one out of the QW-bit
        // field, which yields a defined (if meaningless) q rather than X.
        shift_amt = {2'b00, current_k} + 6'(K_BASE);
        q_calc    = (QW'(1) << shift_amt) - (QW'(q_m) << W) + QW'(1);
    end

    logic               s1_valid;
    logic [IN_BITS-1:0] s1_t;
    logic [QW-1:0]      s1_q;

    // ------------------------------------------------------------------
    // Stage 2: form all three candidates in parallel.
    // ------------------------------------------------------------------
    logic signed [DW-1:0] t_ext;
    logic signed [DW-1:0] q_ext;
    logic signed [DW-1:0] d_sub_c;
    logic signed [DW-1:0] d_add_c;
    logic signed [DW-1:0] d_sub2_c;

    always_comb begin
        t_ext    = {s1_t[IN_BITS-1], s1_t};
        q_ext    = {{(DW-QW){1'b0}}, s1_q};
        d_sub_c  = t_ext - q_ext;
        d_add_c  = t_ext + q_ext;
        d_sub2_c = t_ext - {q_ext[DW-2:0], 1'b0};
    end

    logic                 s2_valid;
    logic signed [DW-1:0] s2_t;
    logic [QW-1:0]        s2_q;
    logic signed [DW-1:0] s2_d_sub;
    logic signed [DW-1:0] s2_d_add;
    logic signed [DW-1:0] s2_d_sub2;

    // ------------------------------------------------------------------
    // Stage 3: pick the candidate by sign tests and flag out-of-range T.
    // ------------------------------------------------------------------
    logic          t_neg;
    logic [DW-1:0] sel;
    logic          err_c;

    always_comb begin
        t_neg = s2_t[DW-1];
        sel   = s2_t;
        if (t_neg) begin
            sel = s2_d_add;
        end else if (!s2_d_sub[DW-1]) begin
            sel = s2_d_sub;
        end
        // T < -q shows up as T + q still negative; T >= 2q as T - 2q non-negative.
        err_c = (t_neg && s2_d_add[DW-1]) || !s2_d_sub2[DW-1];
    end

    // Bits that only matter through their sign, or that are carried along
    // for visibility, are folded here so they are consumed explicitly.
    logic unused_bits;
    assign unused_bits = ^{sel[DW-1:K], s2_q, s2_d_sub2[DW-2:0]};

    // ------------------------------------------------------------------
    // Control path: valid bits and output registers are reset.
    // ------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge value of its source; blocking = here would collapse stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            range_err <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            // Hold the last result during bubbles so stale datapath contents
            // (possibly X straight after reset) never reach the outputs.
            if (s2_valid) begin
                out       <= sel[K-1:0];
                range_err <= err_c;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers: qualified by the valid bits, so no reset needed.
    // ------------------------------------------------------------------
    // NOTE: wide datapath registers are deliberately left without reset;
    // the reset valid bits already mask their contents, and skipping the
    // reset keeps the reset net off several hundred flops.
    always_ff @(posedge clk) begin
        s1_t      <= in;
        s1_q      <= q_calc;
        s2_t      <= t_ext;
        s2_q      <= s1_q;
        s2_d_sub  <= d_sub_c;
        s2_d_add  <= d_add_c;
        s2_d_sub2 <= d_sub2_c;
    end

endmodule

// File: doc/montred_final_sub.md
# montred_final_sub

Final correction stage of the word-level Montgomery reduction chain for special primes q = 2^(current_k+46) − q_m·2^W + 1. It sits directly downstream of the last reduction stage. It takes that stage's signed result T, which lies in [−q, 2q), and maps it into the canonical range [0, q). It is a 3-cycle, fully pipelined valid-tagged datapath that accepts one sample per cycle and flags out-of-range inputs.

## Interface
- K, 54, maximum modulus bit-size (q < 2^K)
- M, 17, bit-size of q_m
- W, 24, word size in bits of the reduction chain
- IN_BITS, K+2, width of the signed input T from the last reduction stage

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  T, q_m and current_k are valid this cycle
- in  in  IN_BITS  signed T (two's complement)
- q_m  in  M  modulus parameter, sampled with in_valid
- current_k  in  4  0→46 … 8→54; sampled with in_valid
- out_valid  out  1  result is valid this cycle
- out  out  K  reduced value in [0, q)
- range_err  out  1  input was outside [−q, 2q); qualified by out_valid

## Operation
- No back-pressure. Every cycle with in_valid=1 produces exactly one out_valid=1 cycle 3 cycles later.
- q_m and current_k travel with each sample through the pipeline.
- Consecutive samples may use different moduli and must not interact.
- current_k > 8 is illegal. Behaviour for it is don't-care, but it must not corrupt neighbouring samples.
- Stage 1 registers the following:
  - T
  - valid
  - q = (1 << (current_k+46)) − (q_m << W) + 1, computed unsigned in K+1 bits
- Stage 2 registers the following, each as a signed IN_BITS+1 difference/sum:
  - T
  - q
  - valid
  - d_sub = T − q
  - d_add = T + q
  - d_sub2 = T − 2q
- Stage 3 selects the result:
  - If T < 0: out = d_add.
  - Else if d_sub ≥ 0: out = d_sub.
  - Else: out = T.
  - Only the low K bits are kept.
- range_err = (T < 0 and d_add < 0) or (d_sub2 ≥ 0).
- When range_err=1, out still follows the selection above; downstream must discard it.
- Bubbles (in_valid=0) propagate as out_valid=0. Datapath registers may hold stale data during bubbles.

## Timing
- Latency is exactly 3 cycles from in_valid to out_valid. Throughput is 1 sample per cycle.
- Reset values:
  - out_valid = 0
  - out = 0
  - range_err = 0
  - all internal valid bits = 0
- Reset asserted mid-operation clears all in-flight valids immediately, asynchronously.
- No out_valid may appear for samples accepted before or during reset.
- The first sample accepted in the cycle after rst deasserts emerges 3 cycles later.
- Boundary cases:
  - T = q−1 → q−1.
  - T = q → 0.
  - T = 2q−1 → q−1.
  - T = −q → 0, no error.
  - T = −q−1 → range_err.
  - T = 2q → range_err.
- The widest arithmetic corner (current_k=8, q_m=0) is q = 2^54+1 minus 0, which requires K+1 bits for q.
  - This combination is illegal upstream.
  - It must still simulate without X.

## Test plan
- Reset sequence: K=54, W=24, M=17, current_k=0, q_m=1, so q=0x3FFF_FF00_0001.
  - Hold rst high, drive in_valid=1 → out_valid=0, out=0, range_err=0 throughout.
  - Release rst → first output 3 cycles after the first accepted sample.
- Same q, back-to-back every cycle:
  - in=5 → out=5
  - in=q+7 → out=7
  - in=−3 → out=0x3FFF_FEFF_FFFE
  - in=q → out=0
  - in=2q−1 → out=q−1
  - All with range_err=0, on 5 consecutive out_valid cycles in order.
- Range errors:
  - in=2q → range_err=1.
  - in=−q−1 → range_err=1.
  - in=−q → out=0, range_err=0.
- Mixed moduli in consecutive cycles:
  - (current_k=8, q_m=0x1_FFFF, in=q8+1) → out=1.
  - (current_k=0, q_m=1, in=q0+2) → out=2.
  - Each is checked against a software model.
- Bubble pattern: in_valid = 1,0,0,1,1,0,1 → out_valid shows the same pattern delayed by 3 cycles; outputs match the model.
- Mid-flight reset: 3 samples in flight, pulse rst for 1 cycle → no out_valid for them; the next accepted sample completes normally with latency 3.
